// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Grant selection helper covers both fixed-priority and round-robin builds.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {ARB_IM, ARB_DM} arb_id_e;

    localparam int MIN_RD_LAT = 1;

    // On conflict DM wins unless round-robin is enabled and DM was granted last.
    function automatic arb_id_e arb_pick(input logic im_req, input logic dm_req,
                                         input logic rr_en, input arb_id_e last);
        if (im_req && dm_req)
            return (rr_en && last == ARB_DM) ? ARB_IM : ARB_DM;
        return dm_req ? ARB_DM : ARB_IM;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side buses of the arbiter; slave = arbiter, master = environment.
interface mem_arbiter_if #(parameter int XLEN = 32);

    logic            i_im_req;
    logic [XLEN-1:0] i_im_addr;
    logic            o_im_ack;
    logic [XLEN-1:0] o_im_rdata;

    logic            i_dm_req;
    logic            i_dm_we;
    logic [XLEN-1:0] i_dm_addr;
    logic [XLEN-1:0] i_dm_wdata;
    logic            o_dm_ack;
    logic [XLEN-1:0] o_dm_rdata;

    logic            o_mem_req;
    logic            o_mem_we;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [XLEN-1:0] i_mem_rdata;
    logic            o_busy;

    modport slave (
        input  i_im_req, i_im_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_mem_rdata,
        output o_im_ack, o_im_rdata, o_dm_ack, o_dm_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
    );

    modport master (
        output i_im_req, i_im_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_mem_rdata,
        input  o_im_ack, o_im_rdata, o_dm_ack, o_dm_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store, one transaction at a time.
// Define MEM_ARBITER_RR_EN for round-robin on conflict; default is fixed DM priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    if (RD_LAT < MIN_RD_LAT) begin : g_bad_rd_lat
        $error("mem_arbiter: RD_LAT must be >= %0d", MIN_RD_LAT);
    end

    arb_state_e      state, state_nxt;
    arb_id_e         gnt_id, gnt_nxt;
    logic            gnt_we;
    logic [XLEN-1:0] gnt_addr, gnt_wdata;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] im_rdata, dm_rdata;
    logic            any_req;

    assign any_req = bus.i_im_req | bus.i_dm_req;

`ifdef MEM_ARBITER_RR_EN
    arb_id_e last_gnt;

    always_ff @(posedge clk) begin
        if (rst)
            last_gnt <= ARB_IM;
        else if (state == IDLE && any_req)
            last_gnt <= gnt_nxt;
    end

    assign gnt_nxt = arb_pick(bus.i_im_req, bus.i_dm_req, 1'b1, last_gnt);
`else
    assign gnt_nxt = arb_pick(bus.i_im_req, bus.i_dm_req, 1'b0, ARB_IM);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = gnt_we ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request payload is latched at grant; later changes on the bus are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_id    <= ARB_IM;
            gnt_we    <= 1'b0;
            gnt_addr  <= '0;
            gnt_wdata <= '0;
            cnt       <= '0;
            im_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt_id    <= gnt_nxt;
                    gnt_we    <= (gnt_nxt == ARB_DM) ? bus.i_dm_we : 1'b0;
                    gnt_addr  <= (gnt_nxt == ARB_DM) ? bus.i_dm_addr : bus.i_im_addr;
                    gnt_wdata <= (gnt_nxt == ARB_DM) ? bus.i_dm_wdata : '0;
                end
                ISSUE: if (!gnt_we) cnt <= CNT_W'(RD_LAT);
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (gnt_id == ARB_IM) im_rdata <= bus.i_mem_rdata;
                        else                  dm_rdata <= bus.i_mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.o_mem_req   = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_im_ack    = 1'b0;
        bus.o_dm_ack    = 1'b0;
        bus.o_busy      = (state != IDLE);
        case (state)
            ISSUE: begin
                bus.o_mem_req   = 1'b1;
                bus.o_mem_we    = gnt_we;
                bus.o_mem_addr  = gnt_addr;
                bus.o_mem_wdata = gnt_wdata;
            end
            RESP: begin
                bus.o_im_ack = (gnt_id == ARB_IM);
                bus.o_dm_ack = (gnt_id == ARB_DM);
            end
            default: ;
        endcase
    end

    assign bus.o_im_rdata = im_rdata;
    assign bus.o_dm_rdata = dm_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level bench for mem_arbiter: timeline model of grant/issue/ack plus a memory responder.
// Directed cases pin exact cycles and values, then a randomized phase with payload churn and resets.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int XLEN     = 32;
    localparam int RD_LAT   = 2;
    localparam int LOAD_ACK = 2 + RD_LAT;
    localparam int LOGN     = 512;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();
    mem_arbiter #(.XLEN(XLEN), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus / control
    txn_t im_q[$], dm_q[$];
    txn_t im_cur = '{1'b0, 32'h0, 32'h0};
    txn_t dm_cur = '{1'b0, 32'h0, 32'h0};
    bit   im_pend, dm_pend;
    bit   rst_force = 1'b1, rand_mode, scramble_en, rst_arm;
    int   rst_at = -1, raise_cyc_im, raise_cyc_dm;

    // model
    bit          m_active, m_rst_prev;
    int          m_tg, m_tack;
    arb_id_e     m_id, m_last = ARB_IM;
    txn_t        m_txn;
    logic [31:0] m_im_rdata, m_dm_rdata;
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] env_mem   [logic [31:0]];
    logic [31:0] rd_sched  [int];

    // per-cycle trace of DUT outputs for the directed literal checks
    logic        log_mem_req[LOGN], log_mem_we[LOGN], log_im_ack[LOGN], log_dm_ack[LOGN], log_busy[LOGN];
    logic [31:0] log_mem_addr[LOGN], log_mem_wdata[LOGN], log_im_rdata[LOGN], log_dm_rdata[LOGN];

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h2000 + ($urandom_range(0, 31) << 2);
    endfunction

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Cycle engine: compare against model, respond as memory, drive requesters, advance model.
    initial begin
        logic        e_issue, e_busy, e_im_ack, e_dm_ack, rst_now;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (m_rst_prev) begin
                m_active = 1'b0; m_im_rdata = '0; m_dm_rdata = '0; m_last = ARB_IM;
            end
            if (m_active && cyc > m_tack) m_active = 1'b0;
            if (m_active && cyc == m_tack && !m_txn.we) begin
                rd = model_mem.exists(m_txn.addr) ? model_mem[m_txn.addr] : memval(m_txn.addr);
                if (m_id == ARB_IM) m_im_rdata = rd; else m_dm_rdata = rd;
            end
            e_issue  = m_active && cyc == m_tg + 1;
            e_busy   = m_active && cyc > m_tg;
            e_im_ack = m_active && cyc == m_tack && m_id == ARB_IM;
            e_dm_ack = m_active && cyc == m_tack && m_id == ARB_DM;

            check_b("busy",      bus.o_busy,      e_busy);
            check_b("mem_req",   bus.o_mem_req,   e_issue);
            check_b("mem_we",    bus.o_mem_we,    e_issue & m_txn.we);
            check_w("mem_addr",  bus.o_mem_addr,  e_issue ? m_txn.addr : 32'h0);
            check_w("mem_wdata", bus.o_mem_wdata, e_issue ? m_txn.wdata : 32'h0);
            check_b("im_ack",    bus.o_im_ack,    e_im_ack);
            check_b("dm_ack",    bus.o_dm_ack,    e_dm_ack);
            check_w("im_rdata",  bus.o_im_rdata,  m_im_rdata);
            check_w("dm_rdata",  bus.o_dm_rdata,  m_dm_rdata);
            if (e_issue && m_txn.we) model_mem[m_txn.addr] = m_txn.wdata;

            if (cyc < LOGN) begin
                log_mem_req[cyc] = bus.o_mem_req;   log_mem_we[cyc] = bus.o_mem_we;
                log_mem_addr[cyc] = bus.o_mem_addr; log_mem_wdata[cyc] = bus.o_mem_wdata;
                log_im_ack[cyc] = bus.o_im_ack;     log_dm_ack[cyc] = bus.o_dm_ack;
                log_im_rdata[cyc] = bus.o_im_rdata; log_dm_rdata[cyc] = bus.o_dm_rdata;
                log_busy[cyc] = bus.o_busy;
            end

            // memory macro: writes land at the strobe, reads return RD_LAT cycles later, noise otherwise
            if (bus.o_mem_req === 1'b1) begin
                if (bus.o_mem_we) env_mem[bus.o_mem_addr] = bus.o_mem_wdata;
                else rd_sched[cyc + RD_LAT] = env_mem.exists(bus.o_mem_addr) ?
                                              env_mem[bus.o_mem_addr] : memval(bus.o_mem_addr);
            end
            if (rd_sched.exists(cyc)) begin
                bus.i_mem_rdata = rd_sched[cyc];
                rd_sched.delete(cyc);
            end else bus.i_mem_rdata = $urandom();

            rst_now = rst_force || cyc == rst_at || (rand_mode && $urandom_range(0, 99) == 0);
            rst = rst_now;
            if (rst_now) begin
                im_pend = 1'b0; dm_pend = 1'b0;
            end else begin
                if (e_im_ack) im_pend = 1'b0;
                if (e_dm_ack) dm_pend = 1'b0;
                if (!im_pend && im_q.size() > 0) begin
                    im_cur = im_q.pop_front(); im_pend = 1'b1; raise_cyc_im = cyc;
                    if (rst_arm) begin rst_at = cyc + 2; rst_arm = 1'b0; end
                end else if (im_pend && scramble_en && $urandom_range(0, 3) == 0)
                    im_cur.addr = rand_addr();
                if (!dm_pend && dm_q.size() > 0) begin
                    dm_cur = dm_q.pop_front(); dm_pend = 1'b1; raise_cyc_dm = cyc;
                end else if (dm_pend && scramble_en && $urandom_range(0, 3) == 0)
                    dm_cur = '{1'($urandom_range(0, 1)), rand_addr(), $urandom()};
            end
            bus.i_im_req   = im_pend;
            bus.i_im_addr  = im_cur.addr;
            bus.i_dm_req   = dm_pend;
            bus.i_dm_we    = dm_cur.we;
            bus.i_dm_addr  = dm_cur.addr;
            bus.i_dm_wdata = dm_cur.wdata;

            // grant decision uses this cycle's inputs
            m_rst_prev = rst_now;
            if (!rst_now && !m_active && (im_pend || dm_pend)) begin
                if (im_pend && dm_pend)
`ifdef MEM_ARBITER_RR_EN
                    m_id = (m_last == ARB_DM) ? ARB_IM : ARB_DM;
`else
                    m_id = ARB_DM;
`endif
                else m_id = dm_pend ? ARB_DM : ARB_IM;
                m_last   = m_id;
                m_txn    = (m_id == ARB_DM) ? dm_cur : '{1'b0, im_cur.addr, 32'h0};
                m_tg     = cyc;
                m_tack   = cyc + (m_txn.we ? 2 : LOAD_ACK);
                m_active = 1'b1;
            end
            cyc++;
        end
    end

    task automatic wait_quiet(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #2;
            done = im_q.size() == 0 && dm_q.size() == 0 && !im_pend && !dm_pend && !m_active;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout after %0d cycles", name, budget);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        int  b;
        bit  any_ack;
        repeat (3) @(posedge clk);
        #2;
        check_b("rst_busy",    bus.o_busy,    1'b0);
        check_b("rst_mem_req", bus.o_mem_req, 1'b0);
        check_b("rst_im_ack",  bus.o_im_ack,  1'b0);
        check_w("rst_im_rd",   bus.o_im_rdata, 32'h0);
        check_w("rst_dm_rd",   bus.o_dm_rdata, 32'h0);
        rst_force = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // IM load
        model_mem[32'h100] = 32'h00500093;
        env_mem[32'h100]   = 32'h00500093;
        im_q.push_back('{1'b0, 32'h100, 32'h0});
        wait_quiet("im_load", 50);
        b = raise_cyc_im;
        check_b("ld_req",   log_mem_req[b+1], 1'b1);
        check_b("ld_we",    log_mem_we[b+1], 1'b0);
        check_w("ld_addr",  log_mem_addr[b+1], 32'h100);
        check_b("ld_early", log_im_ack[b+3], 1'b0);
        check_b("ld_ack",   log_im_ack[b+4], 1'b1);
        check_w("ld_data",  log_im_rdata[b+4], 32'h00500093);
        for (int k = 0; k <= 5; k++)
            check_b("ld_busy", log_busy[b+k], k >= 1 && k <= 4);

        // DM store
        dm_q.push_back('{1'b1, 32'h2000, 32'hDEADBEEF});
        wait_quiet("dm_store", 50);
        b = raise_cyc_dm;
        check_b("st_req",   log_mem_req[b+1], 1'b1);
        check_b("st_we",    log_mem_we[b+1], 1'b1);
        check_w("st_addr",  log_mem_addr[b+1], 32'h2000);
        check_w("st_wdata", log_mem_wdata[b+1], 32'hDEADBEEF);
        check_b("st_ack",   log_dm_ack[b+2], 1'b1);
        check_w("st_rdata", log_dm_rdata[b+2], 32'h0);

        // conflict: both raised in the same cycle
        im_q.push_back('{1'b0, 32'h104, 32'h0});
        dm_q.push_back('{1'b0, 32'h2004, 32'h0});
        wait_quiet("conflict", 80);
        b = raise_cyc_im;
        check_w("cf_same_cyc", 32'(raise_cyc_dm), 32'(b));
`ifdef MEM_ARBITER_RR_EN
        check_b("cf_im_first",  log_im_ack[b+4], 1'b1);
        check_b("cf_dm_second", log_dm_ack[b+9], 1'b1);
`else
        check_b("cf_dm_first",  log_dm_ack[b+4], 1'b1);
        check_b("cf_im_second", log_im_ack[b+9], 1'b1);
`endif
        check_w("cf_dm_data", log_dm_rdata[b+9], memval(32'h2004));

        // back-to-back IM with changed address
        im_q.push_back('{1'b0, 32'h200, 32'h0});
        im_q.push_back('{1'b0, 32'h108, 32'h0});
        wait_quiet("b2b", 80);
        b = raise_cyc_im;
        check_b("b2b_ack1", log_im_ack[b], 1'b1);
        check_b("b2b_idle", log_mem_req[b+1], 1'b0);
        check_b("b2b_req2", log_mem_req[b+2], 1'b1);
        check_w("b2b_addr", log_mem_addr[b+2], 32'h108);

        // reset in cycle 2 of an IM load
        rst_arm = 1'b1;
        im_q.push_back('{1'b0, 32'h300, 32'h0});
        wait_quiet("rst_wait", 50);
        b = raise_cyc_im;
        rst_at = -1;
        any_ack = 1'b0;
        for (int k = 0; k <= 8; k++) any_ack |= log_im_ack[b+k];
        check_b("rw_no_ack",  any_ack, 1'b0);
        check_b("rw_busy",    log_busy[b+3], 1'b0);
        check_b("rw_mem_req", log_mem_req[b+3], 1'b0);
        check_w("rw_im_rd",   log_im_rdata[b+3], 32'h0);
        check_w("rw_dm_rd",   log_dm_rdata[b+3], 32'h0);
        im_q.push_back('{1'b0, 32'h100, 32'h0});
        wait_quiet("rst_after", 50);
        b = raise_cyc_im;
        check_b("ra_ack",  log_im_ack[b+4], 1'b1);
        check_w("ra_data", log_im_rdata[b+4], 32'h00500093);

        // randomized traffic
        rand_mode = 1'b1;
        scramble_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (im_q.size() < 2 && $urandom_range(0, 4) == 0)
                im_q.push_back('{1'b0, rand_addr(), 32'h0});
            if (dm_q.size() < 2 && $urandom_range(0, 4) == 0)
                dm_q.push_back('{1'($urandom_range(0, 1)), rand_addr(), $urandom()});
        end
        rand_mode = 1'b0;
        scramble_en = 1'b0;
        wait_quiet("drain", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
